multiplexer_nto1_arb: RTL

//  Parametrised N-to-1 WIDTH-bit multiplexer with per-channel valid/ready handshake and registered output.
//  Two modes: fixed select (external sel, like the 4-to-1 32-bit mux) or round-robin arbitration.

---
 rtl/multiplexer_nto1_arb.sv | 68 ++++++
 1 files changed

// File: rtl/multiplexer_nto1_arb.sv
// multiplexer_nto1_arb: N-to-1 valid/ready mux with registered output, fixed-select or round-robin grant
module multiplexer_nto1_arb #(
  parameter int N = 4,
  parameter int WIDTH = 32,
  parameter int MODE = 0,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]   sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_ch
);
  logic [SEL_W-1:0] gnt_idx, rr_nxt, rr_ptr_q, rr_ptr_d, out_ch_q, out_ch_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic gnt_vld, load, out_valid_q, out_valid_d;
  int idx;
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx = 0;
    if (MODE == 0) begin
      for (int i = 0; i < N; i++)
        if (sel == SEL_W'(i) && in_valid[i]) begin
          gnt_vld = 1'b1;
          gnt_idx = SEL_W'(i);
        end
    end else begin
      // walk the ring backwards so the channel closest to rr_ptr wins last
      for (int k = N - 1; k >= 0; k--) begin
        idx = int'(rr_ptr_q) + k;
        idx = (idx >= N) ? idx - N : idx;
        if (in_valid[idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = SEL_W'(idx);
        end
      end
    end
    load = rst_n && (!out_valid_q || out_ready);
    in_ready = (load && gnt_vld) ? ({{(N-1){1'b0}}, 1'b1} << gnt_idx) : '0;
    rr_nxt = (gnt_idx == SEL_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
    out_valid_d = load ? gnt_vld : out_valid_q;
    out_data_d = (load && gnt_vld) ? in_data[int'(gnt_idx)*WIDTH +: WIDTH] : out_data_q;
    out_ch_d = (load && gnt_vld) ? gnt_idx : out_ch_q;
    rr_ptr_d = (MODE == 1 && load && gnt_vld) ? rr_nxt : rr_ptr_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_ch_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_ch_q <= out_ch_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_ch = out_ch_q;
endmodule
